pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central sequencer for the five-stage pipeline. It drives the en/flush pair of every inter-stage latch (if_id, id_ex, ex_mem, mem_wb) and the PC enable. It resolves data-cache waits, instruction-fetch misses, load-use hazards, control redirects and halt. It also keeps saturating stall and flush counters and a data-wait watchdog. There is one instance per core.

Parameters:
CNT_W, 32, width of performance counters
DWAIT_TIMEOUT, 1024, consecutive DWAIT cycles before timeout_err is raised

Ports:
CLK  in  1  clock
nRST  in  1  reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_dren  in  1  MEM-stage instruction reads dmem (ex_mem output)
mem_dwen  in  1  MEM-stage instruction writes dmem
redirect  in  1  MEM-stage branch/jump needs PC redirect
ex_memread  in  1  EX-stage instruction is a load (id_ex output)
ex_rd  in  5  EX-stage destination register
id_rs1  in  5  ID-stage source 1
id_rs2  in  5  ID-stage source 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
wb_halt  in  1  halt_o of mem_wb latch
pc_en  out  1  PC register load enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes; a flush takes effect only with en=1
halt  out  1  core halted (sticky)
timeout_err  out  1  data wait exceeded DWAIT_TIMEOUT (sticky)
stall_cnt  out  CNT_W  stall cycles
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Reset is asynchronous, active-low, on nRST; the block is clocked by CLK. On reset: state=RUN, halt=0, timeout_err=0, stall_cnt=0, flush_cnt=0, wait counter=0.
- Latch controls and pc_en are combinational from state and inputs.
- Terms:
  - mem_busy = (mem_dren|mem_dwen) & !dhit
  - lu = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
- States: RUN, DWAIT, HALTED.
- Priority in RUN/DWAIT, first match wins:
  1. wb_halt: all four latches en=1, flush=1; pc_en=0; next state=HALTED.
  2. mem_busy: pc, ifid, idex, exmem en=0 (hold); memwb en=1, flush=1 (WB bubble); stall_cnt++; next state=DWAIT.
  3. redirect: ifid, idex, exmem en=1, flush=1; memwb en=1, flush=0; pc_en=1; flush_cnt++; next state=RUN.
  4. lu: pc_en=0; ifid en=0; idex en=1, flush=1; exmem, memwb en=1; stall_cnt++; next state=RUN.
  5. !ihit: pc_en=0; ifid en=1, flush=1; idex, exmem, memwb en=1; stall_cnt++; next state=RUN.
  6. otherwise: all en=1, flush=0, pc_en=1; next state=RUN.
- DWAIT exits on the dhit cycle. In that cycle mem_busy=0, so rules 3–6 apply and memwb captures the load data in the same cycle. Latency from dhit to data in mem_wb is one edge.
- Wait counter: cleared when entering DWAIT and incremented each DWAIT cycle with !dhit. When it reaches DWAIT_TIMEOUT, timeout_err=1. The block keeps stalling; there is no auto-recovery.
- HALTED: pc_en=0; all latches en=1, flush=1; halt=1. There is no exit except reset. Counters freeze.
- Both counters saturate at all-ones and do not wrap.
- Simultaneous events:
  - redirect & mem_busy: stall wins; redirect is re-evaluated when exmem releases.
  - redirect & lu: redirect wins.
  - wb_halt & anything: halt wins.
  - mem_busy & !ihit: a single stall_cnt increment.
- Reset mid-DWAIT returns to RUN, clearing all counters and flags.

Decomposition:
- In cpu_types_pkg: typedef enum logic [1:0] pipe_state_t {RUN, DWAIT, HALTED}.
- Sub-module sat_counter (parameter W; ports clk, nRST, inc, clr, count), instanced for stall_cnt, flush_cnt and the wait counter.

Test Plan:
- Reset, then ihit=1 and no hazards for 5 cycles -> all en=1, flush=0, pc_en=1, stall_cnt=0.
- mem_dren=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of exmem_en=0, memwb_en=1, memwb_flush=1, state=DWAIT; on the dhit cycle all en=1; stall_cnt=3.
- ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_cnt=1.
- redirect=1 together with the load-use condition -> ifid/idex/exmem flush=1, pc_en=1, flush_cnt=1, no stall_cnt increment.
- wb_halt=1 while mem_busy=1 -> halt=1 next edge; all latches flush; state stays HALTED after wb_halt drops.
- DWAIT_TIMEOUT=4, dhit held 0 -> timeout_err=1 after 4 DWAIT cycles; nRST low mid-wait clears it and state=RUN.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline sequencer: FSM states, the latch-control bundle,
// and the load-use hazard test.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    // en/flush bit order, MSB first: if_id, id_ex, ex_mem, mem_wb
    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [3:0] flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN        = '{pc_en: 1'b1, en: 4'b1111, flush: 4'b0000};
    localparam pipe_ctrl_t CTRL_HALT       = '{pc_en: 1'b0, en: 4'b1111, flush: 4'b1111};
    localparam pipe_ctrl_t CTRL_MEM_WAIT   = '{pc_en: 1'b0, en: 4'b0001, flush: 4'b0001};
    localparam pipe_ctrl_t CTRL_REDIRECT   = '{pc_en: 1'b1, en: 4'b1111, flush: 4'b1110};
    localparam pipe_ctrl_t CTRL_LOAD_USE   = '{pc_en: 1'b0, en: 4'b0111, flush: 4'b0100};
    localparam pipe_ctrl_t CTRL_FETCH_MISS = '{pc_en: 1'b0, en: 4'b1111, flush: 4'b1000};

    // x0 is hardwired, so a load targeting it never creates a hazard.
    function automatic logic load_use(
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_use_rs1,
        input logic       id_use_rs2
    );
        return ex_memread && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: latch en/flush and PC enable from hazards, dcache waits,
// redirects and halt, plus stall/flush counters and a data-wait watchdog.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int DWAIT_TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             redirect,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = $clog2(DWAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DWAIT_TIMEOUT - 1);

    pipe_state_t       state, next_state;
    pipe_ctrl_t        ctrl;
    logic              mem_busy, lu;
    logic              stall_inc, flush_inc, wait_inc, wait_clr;
    logic [WAIT_W-1:0] wait_cnt;

    assign mem_busy = (mem_dren | mem_dwen) & ~dhit;
    assign lu       = load_use(ex_memread, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl       = CTRL_RUN;
        next_state = state;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (state == HALTED) begin
            ctrl = CTRL_HALT;
        end else begin
            next_state = RUN;
            if (wb_halt) begin
                ctrl       = CTRL_HALT;
                next_state = HALTED;
            end else if (mem_busy) begin
                // Redirect is deliberately shadowed; it is seen again once ex_mem releases.
                ctrl       = CTRL_MEM_WAIT;
                stall_inc  = 1'b1;
                next_state = DWAIT;
            end else if (redirect) begin
                ctrl      = CTRL_REDIRECT;
                flush_inc = 1'b1;
            end else if (lu) begin
                ctrl      = CTRL_LOAD_USE;
                stall_inc = 1'b1;
            end else if (!ihit) begin
                ctrl      = CTRL_FETCH_MISS;
                stall_inc = 1'b1;
            end
        end
    end

    assign pc_en = ctrl.pc_en;
    assign {ifid_en, idex_en, exmem_en, memwb_en}             = ctrl.en;
    assign {ifid_flush, idex_flush, exmem_flush, memwb_flush} = ctrl.flush;
    assign halt  = (state == HALTED);

    assign wait_inc = (state == DWAIT) & ~dhit;
    assign wait_clr = (state != DWAIT) & (next_state == DWAIT);

    // Sticky: the core keeps stalling after a timeout until software resets it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            timeout_err <= 1'b0;
        end else if (wait_inc && (wait_cnt >= WAIT_LAST)) begin
            timeout_err <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(CLK), .nRST(nRST), .inc(stall_inc), .clr(1'b0), .count(stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(CLK), .nRST(nRST), .inc(flush_inc), .clr(1'b0), .count(flush_cnt)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk(CLK), .nRST(nRST), .inc(wait_inc), .clr(wait_clr), .count(wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// against a rule-level reference model.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 4;
    localparam int TO      = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, mem_dren, mem_dwen, redirect, ex_memread;
    logic [4:0]       ex_rd, id_rs1, id_rs2;
    logic             id_use_rs1, id_use_rs2, wb_halt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic             halt, timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_halted, m_waiting, m_timeout;
    int m_wait, m_stall, m_flush;

    wire [8:0] act_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                           ifid_flush, idex_flush, exmem_flush, memwb_flush};

    pipeline_ctrl #(.CNT_W(CNT_W), .DWAIT_TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .redirect(redirect),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Rule number that applies this cycle: 0 halted, 1 wb_halt, 2 dmem busy,
    // 3 redirect, 4 load-use, 5 fetch miss, 6 normal flow.
    function automatic int rule_now();
        logic busy, hz;
        busy = (mem_dren || mem_dwen) && !dhit;
        hz   = ex_memread && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (m_halted) return 0;
        if (wb_halt)  return 1;
        if (busy)     return 2;
        if (redirect) return 3;
        if (hz)       return 4;
        if (!ihit)    return 5;
        return 6;
    endfunction

    // {pc_en, en[ifid,idex,exmem,memwb], flush[ifid,idex,exmem,memwb]}
    function automatic logic [8:0] ctrl_for(input int r);
        case (r)
            0, 1:    return 9'b0_1111_1111;
            2:       return 9'b0_0001_0001;
            3:       return 9'b1_1111_1110;
            4:       return 9'b0_0111_0100;
            5:       return 9'b0_1111_1000;
            default: return 9'b1_1111_0000;
        endcase
    endfunction

    task automatic model_reset();
        m_halted = 0; m_waiting = 0; m_timeout = 0;
        m_wait = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_edge(input int r, input logic dh);
        if (m_waiting && !dh) begin
            if (m_wait < TO) m_wait++;
            if (m_wait >= TO) m_timeout = 1;
        end else if (!m_waiting && r == 2) begin
            m_wait = 0;
        end
        if ((r == 2 || r == 4 || r == 5) && m_stall < CNT_MAX) m_stall++;
        if (r == 3 && m_flush < CNT_MAX) m_flush++;
        m_waiting = (r == 2);
        if (r == 1) m_halted = 1;
    endtask

    task automatic tick();
        int   r;
        logic dh;
        r  = rule_now();
        dh = dhit;
        @(posedge CLK);
        model_edge(r, dh);
        #1;
    endtask

    task automatic drive_idle();
        ihit = 1; dhit = 0; mem_dren = 0; mem_dwen = 0; redirect = 0; ex_memread = 0;
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; wb_halt = 0;
    endtask

    task automatic apply_reset();
        nRST = 0;
        drive_idle();
        #2;
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1;
    endtask

    task automatic test_reset();
        nRST = 0;
        drive_idle();
        #2;
        model_reset();
        checks++;
        if ({halt, timeout_err, stall_cnt, flush_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state got halt=%b tmo=%b stall=%0d flush=%0d expected all 0",
                     halt, timeout_err, stall_cnt, flush_cnt);
        end
        @(posedge CLK);
        #1;
        nRST = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (act_ctrl !== 9'b1_1111_0000) begin
                failures++;
                $display("FAIL run_ctrl cyc=%0d got=%b expected=%b", i, act_ctrl, 9'b1_1111_0000);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 0) begin
            failures++;
            $display("FAIL run_stall got=%0d expected=0", stall_cnt);
        end
    endtask

    task automatic test_dwait();
        apply_reset();
        mem_dren = 1;
        dhit     = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (act_ctrl !== 9'b0_0001_0001) begin
                failures++;
                $display("FAIL dwait_hold cyc=%0d got=%b expected=%b", i, act_ctrl, 9'b0_0001_0001);
            end
            tick();
        end
        dhit = 1;
        #1;
        checks++;
        if (act_ctrl !== 9'b1_1111_0000) begin
            failures++;
            $display("FAIL dwait_release got=%b expected=%b", act_ctrl, 9'b1_1111_0000);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd3) begin
            failures++;
            $display("FAIL dwait_stall got=%0d expected=3", stall_cnt);
        end
        drive_idle();
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_rd = 0; ex_memread = 1; id_rs2 = 0; id_use_rs2 = 1;
        #1;
        checks++;
        if (act_ctrl !== 9'b1_1111_0000) begin
            failures++;
            $display("FAIL lu_x0 got=%b expected=%b", act_ctrl, 9'b1_1111_0000);
        end
        tick();
        ex_rd = 5; id_rs2 = 5;
        #1;
        checks++;
        if (act_ctrl !== 9'b0_0111_0100) begin
            failures++;
            $display("FAIL lu_ctrl got=%b expected=%b", act_ctrl, 9'b0_0111_0100);
        end
        tick();
        drive_idle();
        checks++;
        if (stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL lu_stall got=%0d expected=1", stall_cnt);
        end
    endtask

    task automatic test_redirect_lu();
        apply_reset();
        redirect = 1; ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        #1;
        checks++;
        if (act_ctrl !== 9'b1_1111_1110) begin
            failures++;
            $display("FAIL redir_ctrl got=%b expected=%b", act_ctrl, 9'b1_1111_1110);
        end
        tick();
        drive_idle();
        checks++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin
            failures++;
            $display("FAIL redir_counts got flush=%0d stall=%0d expected flush=1 stall=0",
                     flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        wb_halt = 1; mem_dren = 1; dhit = 0;
        #1;
        checks++;
        if (act_ctrl !== 9'b0_1111_1111) begin
            failures++;
            $display("FAIL halt_ctrl got=%b expected=%b", act_ctrl, 9'b0_1111_1111);
        end
        tick();
        drive_idle();
        ihit = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({halt, act_ctrl, stall_cnt} !== {1'b1, 9'b0_1111_1111, 4'd0}) begin
                failures++;
                $display("FAIL halt_sticky cyc=%0d got halt=%b ctrl=%b stall=%0d expected 1/%b/0",
                         i, halt, act_ctrl, stall_cnt, 9'b0_1111_1111);
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_dren = 1; dhit = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL tmo_early cyc=%0d got=%b expected=0", i, timeout_err);
            end
            tick();
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_raise got=%b expected=1", timeout_err);
        end
        #2;
        nRST = 0;
        #1;
        model_reset();
        checks++;
        if ({timeout_err, halt, stall_cnt} !== '0) begin
            failures++;
            $display("FAIL tmo_reset got tmo=%b halt=%b stall=%0d expected all 0",
                     timeout_err, halt, stall_cnt);
        end
        @(posedge CLK);
        #1;
        nRST = 1;
        // Fresh RUN state: a new wait needs the full budget again before timing out.
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL tmo_rearm cyc=%0d got=%b expected=0", i, timeout_err);
            end
            tick();
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_reraise got=%b expected=1", timeout_err);
        end
        drive_idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        ihit = 0;
        for (int i = 0; i < CNT_MAX + 5; i++) tick();
        checks++;
        if (stall_cnt !== CNT_W'(CNT_MAX)) begin
            failures++;
            $display("FAIL stall_sat got=%0d expected=%0d", stall_cnt, CNT_MAX);
        end
        ihit = 1; redirect = 1;
        for (int i = 0; i < CNT_MAX + 3; i++) tick();
        checks++;
        if (flush_cnt !== CNT_W'(CNT_MAX)) begin
            failures++;
            $display("FAIL flush_sat got=%0d expected=%0d", flush_cnt, CNT_MAX);
        end
        drive_idle();
    endtask

    task automatic test_random();
        int halted_for;
        apply_reset();
        halted_for = 0;
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 150) == 0 || halted_for > 4) begin
                apply_reset();
                halted_for = 0;
            end
            ihit       = ($urandom % 5) != 0;
            dhit       = ($urandom % 3) == 0;
            mem_dren   = ($urandom % 4) == 0;
            mem_dwen   = ($urandom % 8) == 0;
            redirect   = ($urandom % 6) == 0;
            ex_memread = ($urandom % 3) == 0;
            ex_rd      = 5'($urandom % 4);
            id_rs1     = 5'($urandom % 4);
            id_rs2     = 5'($urandom % 4);
            id_use_rs1 = $urandom % 2;
            id_use_rs2 = $urandom % 2;
            wb_halt    = ($urandom % 60) == 0;
            #1;
            checks++;
            if ({act_ctrl, halt, timeout_err, stall_cnt, flush_cnt} !==
                {ctrl_for(rule_now()), m_halted, m_timeout, CNT_W'(m_stall), CNT_W'(m_flush)}) begin
                failures++;
                $display("FAIL rand cyc=%0d got ctrl=%b halt=%b tmo=%b stall=%0d flush=%0d expected ctrl=%b halt=%b tmo=%b stall=%0d flush=%0d",
                         i, act_ctrl, halt, timeout_err, stall_cnt, flush_cnt,
                         ctrl_for(rule_now()), m_halted, m_timeout, m_stall, m_flush);
            end
            tick();
            if (m_halted) halted_for++;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_dwait();
        test_load_use();
        test_redirect_lu();
        test_halt();
        test_timeout();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
